// File: rtl/mode7_param_scheduler.sv
// -----------------------------------------------------------------------------
// mode7_param_scheduler
//
// Owns the Mode 7 transform parameters feeding the getXY datapath. The host
// writes shadow registers through a valid/ready port; shadow values are copied
// to the live outputs only at the vertical-blank boundary, so a frame never
// tears. After each commit an optional auto-animation step advances the angle
// and Y offset, and an optional per-scanline ramp adjusts the scale.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   pixel_x, pixel_y     vga_sync counters
//   p_tick               vga_sync pixel enable
//   wr_valid/wr_ready    host write handshake (accepted when both high)
//   wr_addr, wr_data     register select and write data
//   originx, originy     live origin
//   angle                live angle, 0..ENT_TABLA-1
//   offsetx, offsety     live offsets
//   scalex, scaley       live scale, unsigned 16.8 fixed point
//   commit               one-cycle pulse when shadow has been copied to live
//   err                  sticky flag: an out-of-range angle was written
// -----------------------------------------------------------------------------
module mode7_param_scheduler #(
  parameter int ENT_TABLA = 360,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int SCALE_W   = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               p_tick,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [2:0]         wr_addr,
  input  logic [23:0]        wr_data,
  output logic [9:0]         originx,
  output logic [9:0]         originy,
  output logic [9:0]         angle,
  output logic [15:0]        offsetx,
  output logic [15:0]        offsety,
  output logic [SCALE_W-1:0] scalex,
  output logic [SCALE_W-1:0] scaley,
  output logic               commit,
  output logic               err
);

  localparam logic [9:0]         ANGLE_LIM = 10'(ENT_TABLA);
  localparam logic [9:0]         X_LAST    = 10'(H_ACTIVE - 1);
  localparam logic [9:0]         Y_VBLANK  = 10'(V_ACTIVE);
  localparam logic [SCALE_W-1:0] SCALE_ONE = SCALE_W'(256);
  localparam logic [9:0]         ORIGIN_RST = 10'd32;

  localparam logic [2:0] A_ORIGINX = 3'd0;
  localparam logic [2:0] A_ORIGINY = 3'd1;
  localparam logic [2:0] A_ANGLE   = 3'd2;
  localparam logic [2:0] A_OFFSETX = 3'd3;
  localparam logic [2:0] A_OFFSETY = 3'd4;
  localparam logic [2:0] A_SBASE   = 3'd5;
  localparam logic [2:0] A_SSTEP   = 3'd6;
  localparam logic [2:0] A_CTRL    = 3'd7;

  typedef enum logic [1:0] {
    S_ACTIVE = 2'd0,
    S_COMMIT = 2'd1,
    S_ANIM   = 2'd2
  } state_t;

  state_t r_state;

  // Shadow copies (host side)
  logic [9:0]         r_sh_originx, r_sh_originy, r_sh_angle;
  logic [15:0]        r_sh_offsetx, r_sh_offsety;
  logic [SCALE_W-1:0] r_sh_base;
  logic [15:0]        r_sh_step;
  logic               r_sh_anim_en, r_sh_persp_en;
  logic [3:0]         r_sh_angle_step;
  logic [7:0]         r_sh_frame_div;

  // Live copies (getXY side)
  logic [9:0]         r_lv_originx, r_lv_originy, r_lv_angle;
  logic [15:0]        r_lv_offsetx, r_lv_offsety;
  logic [SCALE_W-1:0] r_lv_base;
  logic [15:0]        r_lv_step;
  logic               r_lv_anim_en, r_lv_persp_en;
  logic [3:0]         r_lv_angle_step;
  logic [7:0]         r_lv_frame_div;

  logic [SCALE_W-1:0] r_acc;
  logic [SCALE_W-1:0] r_scale;
  logic [7:0]         r_frame_cnt;
  logic               r_wr_ready;
  logic               r_commit;
  logic               r_err;

  // Event decode
  logic w_frame_evt, w_line_evt, w_wr_fire;

  assign w_frame_evt = p_tick && (pixel_x == 10'd0) && (pixel_y == Y_VBLANK);
  assign w_line_evt  = p_tick && (pixel_x == X_LAST) && (pixel_y < Y_VBLANK);
  assign w_wr_fire   = wr_valid && r_wr_ready && (r_state == S_ACTIVE);

  // Shadow values with this cycle's write merged in. Used both to update the
  // shadow and to feed a commit in the same cycle, so a write accepted on the
  // frame_evt cycle makes it into that commit.
  logic [9:0]         w_sh_originx, w_sh_originy, w_sh_angle;
  logic [15:0]        w_sh_offsetx, w_sh_offsety;
  logic [SCALE_W-1:0] w_sh_base;
  logic [15:0]        w_sh_step;
  logic               w_sh_anim_en, w_sh_persp_en;
  logic [3:0]         w_sh_angle_step;
  logic [7:0]         w_sh_frame_div;
  logic               w_err_set;

  always_comb begin
    w_sh_originx    = r_sh_originx;
    w_sh_originy    = r_sh_originy;
    w_sh_angle      = r_sh_angle;
    w_sh_offsetx    = r_sh_offsetx;
    w_sh_offsety    = r_sh_offsety;
    w_sh_base       = r_sh_base;
    w_sh_step       = r_sh_step;
    w_sh_anim_en    = r_sh_anim_en;
    w_sh_persp_en   = r_sh_persp_en;
    w_sh_angle_step = r_sh_angle_step;
    w_sh_frame_div  = r_sh_frame_div;
    w_err_set       = 1'b0;
    if (w_wr_fire) begin
      case (wr_addr)
        A_ORIGINX: w_sh_originx = wr_data[9:0];
        A_ORIGINY: w_sh_originy = wr_data[9:0];
        A_ANGLE: begin
          // Out-of-range angles are swallowed; the shadow keeps its value.
          if (wr_data[9:0] < ANGLE_LIM) begin
            w_sh_angle = wr_data[9:0];
          end else begin
            w_err_set = 1'b1;
          end
        end
        A_OFFSETX: w_sh_offsetx = wr_data[15:0];
        A_OFFSETY: w_sh_offsety = wr_data[15:0];
        A_SBASE:   w_sh_base    = wr_data[SCALE_W-1:0];
        A_SSTEP:   w_sh_step    = wr_data[15:0];
        A_CTRL: begin
          w_sh_anim_en    = wr_data[0];
          w_sh_persp_en   = wr_data[1];
          w_sh_angle_step = wr_data[5:2];
          w_sh_frame_div  = wr_data[15:8];
        end
      endcase
    end
  end

  // Per-line scale accumulator: add the signed step, clamp to [0, 2^W-1].
  logic signed [SCALE_W+1:0] w_acc_sum;
  logic [SCALE_W-1:0]        w_acc_next;

  always_comb begin
    w_acc_sum = $signed({2'b00, r_acc})
              + $signed({{(SCALE_W + 2 - 16){r_lv_step[15]}}, r_lv_step});
    if (w_acc_sum[SCALE_W+1]) begin
      w_acc_next = '0;
    end else if (w_acc_sum[SCALE_W]) begin
      w_acc_next = '1;
    end else begin
      w_acc_next = w_acc_sum[SCALE_W-1:0];
    end
  end

  // Animated angle: a single conditional subtract suffices since step <= 15.
  logic [10:0] w_angle_sum;
  logic [9:0]  w_angle_stepped;

  always_comb begin
    w_angle_sum = {1'b0, r_lv_angle} + {7'd0, r_lv_angle_step};
    if (w_angle_sum >= {1'b0, ANGLE_LIM}) begin
      w_angle_stepped = w_angle_sum[9:0] - ANGLE_LIM;
    end else begin
      w_angle_stepped = w_angle_sum[9:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_ACTIVE;
      r_sh_originx    <= ORIGIN_RST;
      r_sh_originy    <= ORIGIN_RST;
      r_sh_angle      <= '0;
      r_sh_offsetx    <= '0;
      r_sh_offsety    <= '0;
      r_sh_base       <= SCALE_ONE;
      r_sh_step       <= '0;
      r_sh_anim_en    <= 1'b0;
      r_sh_persp_en   <= 1'b0;
      r_sh_angle_step <= '0;
      r_sh_frame_div  <= '0;
      r_lv_originx    <= ORIGIN_RST;
      r_lv_originy    <= ORIGIN_RST;
      r_lv_angle      <= '0;
      r_lv_offsetx    <= '0;
      r_lv_offsety    <= '0;
      r_lv_base       <= SCALE_ONE;
      r_lv_step       <= '0;
      r_lv_anim_en    <= 1'b0;
      r_lv_persp_en   <= 1'b0;
      r_lv_angle_step <= '0;
      r_lv_frame_div  <= '0;
      r_acc           <= SCALE_ONE;
      r_scale         <= SCALE_ONE;
      r_frame_cnt     <= '0;
      r_wr_ready      <= 1'b1;
      r_commit        <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      // Scanline ramp runs in every state; the output follows it only when
      // perspective mode is live. A commit below overrides both registers.
      if (w_line_evt) begin
        r_acc <= w_acc_next;
        if (r_lv_persp_en) begin
          r_scale <= w_acc_next;
        end
      end

      case (r_state)
        S_ACTIVE: begin
          r_sh_originx    <= w_sh_originx;
          r_sh_originy    <= w_sh_originy;
          r_sh_angle      <= w_sh_angle;
          r_sh_offsetx    <= w_sh_offsetx;
          r_sh_offsety    <= w_sh_offsety;
          r_sh_base       <= w_sh_base;
          r_sh_step       <= w_sh_step;
          r_sh_anim_en    <= w_sh_anim_en;
          r_sh_persp_en   <= w_sh_persp_en;
          r_sh_angle_step <= w_sh_angle_step;
          r_sh_frame_div  <= w_sh_frame_div;
          if (w_err_set) begin
            r_err <= 1'b1;
          end
          if (w_frame_evt) begin
            r_lv_originx    <= w_sh_originx;
            r_lv_originy    <= w_sh_originy;
            r_lv_angle      <= w_sh_angle;
            r_lv_offsetx    <= w_sh_offsetx;
            r_lv_offsety    <= w_sh_offsety;
            r_lv_base       <= w_sh_base;
            r_lv_step       <= w_sh_step;
            r_lv_anim_en    <= w_sh_anim_en;
            r_lv_persp_en   <= w_sh_persp_en;
            r_lv_angle_step <= w_sh_angle_step;
            r_lv_frame_div  <= w_sh_frame_div;
            // Accumulator restarts at the base, so the scale output equals
            // the base in both modes right after a commit.
            r_acc           <= w_sh_base;
            r_scale         <= w_sh_base;
            r_commit        <= 1'b1;
            r_wr_ready      <= 1'b0;
            r_state         <= S_COMMIT;
          end
        end

        S_COMMIT: begin
          r_commit <= 1'b0;
          r_state  <= S_ANIM;
        end

        S_ANIM: begin
          if (r_lv_anim_en) begin
            if (r_frame_cnt == r_lv_frame_div) begin
              r_frame_cnt  <= '0;
              r_lv_angle   <= w_angle_stepped;
              r_lv_offsety <= r_lv_offsety + 16'd1;
              // Write back so the next commit continues the animation.
              r_sh_angle   <= w_angle_stepped;
              r_sh_offsety <= r_lv_offsety + 16'd1;
            end else begin
              r_frame_cnt <= r_frame_cnt + 8'd1;
            end
          end
          r_wr_ready <= 1'b1;
          r_state    <= S_ACTIVE;
        end

        default: begin
          r_commit   <= 1'b0;
          r_wr_ready <= 1'b1;
          r_state    <= S_ACTIVE;
        end
      endcase
    end
  end

  assign wr_ready = r_wr_ready;
  assign originx  = r_lv_originx;
  assign originy  = r_lv_originy;
  assign angle    = r_lv_angle;
  assign offsetx  = r_lv_offsetx;
  assign offsety  = r_lv_offsety;
  assign scalex   = r_scale;
  assign scaley   = r_scale;
  assign commit   = r_commit;
  assign err      = r_err;

endmodule

// File: tb/tb_mode7_param_scheduler.sv
`timescale 1ns/1ps
module tb_mode7_param_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x, pixel_y;
  logic        p_tick;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_addr;
  logic [23:0] wr_data;
  logic [9:0]  originx, originy, angle;
  logic [15:0] offsetx, offsety;
  logic [23:0] scalex, scaley;
  logic        commit, err;

  mode7_param_scheduler #(
    .ENT_TABLA(360), .H_ACTIVE(640), .V_ACTIVE(480), .SCALE_W(24)
  ) dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .p_tick(p_tick), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .originx(originx),
    .originy(originy), .angle(angle), .offsetx(offsetx), .offsety(offsety),
    .scalex(scalex), .scaley(scaley), .commit(commit), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural model: register file indexed by address, shadow and live.
  int sh[8];
  int lv[8];
  int acc, cnt, phase;   // phase: cycles since frame_evt was taken (0 = open)
  bit m_commit, m_err, m_valid;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  function automatic int mask_of(input int a);
    case (a)
      0, 1, 2: return 'h3FF;
      5:       return 'hFFFFFF;
      default: return 'hFFFF;
    endcase
  endfunction

  task automatic model_reset();
    sh = '{32, 32, 0, 0, 0, 'h100, 0, 0};
    lv = sh;
    acc = 'h100; cnt = 0; phase = 0;
    m_commit = 0; m_err = 0; m_valid = 1;
  endtask

  task automatic model_step();
    bit fire, fev, lev;
    int s, a, d;
    if (reset) begin
      model_reset();
      return;
    end
    d    = int'(wr_data);
    fire = wr_valid && (phase == 0);
    fev  = p_tick && pixel_x == 0 && pixel_y == 480;
    lev  = p_tick && pixel_x == 639 && pixel_y < 480;
    if (fire) begin
      if (wr_addr == 2 && (d & 'h3FF) >= 360) m_err = 1;
      else sh[wr_addr] = d & mask_of(int'(wr_addr));
    end
    if (lev) begin
      s = lv[6];
      if (s >= 32768) s -= 65536;
      acc += s;
      if (acc < 0) acc = 0;
      if (acc > 'hFFFFFF) acc = 'hFFFFFF;
    end
    m_commit = 0;
    if (phase == 0) begin
      if (fev) begin
        lv = sh;
        acc = sh[5];
        m_commit = 1;
        phase = 1;
      end
    end else if (phase == 1) begin
      phase = 2;
    end else begin
      if (lv[7] & 1) begin
        if (cnt == ((lv[7] >> 8) & 255)) begin
          cnt = 0;
          a = lv[2] + ((lv[7] >> 2) & 15);
          if (a >= 360) a -= 360;
          lv[2] = a; sh[2] = a;
          lv[4] = (lv[4] + 1) & 'hFFFF; sh[4] = lv[4];
        end else begin
          cnt = (cnt + 1) & 255;
        end
      end
      phase = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin : cmp
    int s;
    if (m_valid) begin
      s = ((lv[7] >> 1) & 1) ? acc : lv[5];
      check("wr_ready", 32'(wr_ready), 32'(phase == 0));
      check("originx",  32'(originx),  lv[0]);
      check("originy",  32'(originy),  lv[1]);
      check("angle",    32'(angle),    lv[2]);
      check("offsetx",  32'(offsetx),  lv[3]);
      check("offsety",  32'(offsety),  lv[4]);
      check("scalex",   32'(scalex),   s);
      check("scaley",   32'(scaley),   s);
      check("commit",   32'(commit),   32'(m_commit));
      check("err",      32'(err),      32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic idle_coords();
    p_tick = 1'b1; pixel_x = 10'd100; pixel_y = 10'd100;
  endtask

  task automatic idle(input int n);
    idle_coords();
    wr_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic write(input int a, input int d);
    wr_valid = 1'b1; wr_addr = 3'(a); wr_data = 24'(d);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic frame();
    p_tick = 1'b1; pixel_x = 10'd0; pixel_y = 10'd480;
    tick();
    idle_coords();
  endtask

  task automatic frame_full();
    frame();
    tick();
    tick();
  endtask

  task automatic line(input int y);
    p_tick = 1'b1; pixel_x = 10'd639; pixel_y = 10'(y);
    tick();
    idle_coords();
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    p_tick = 1'b0; pixel_x = 10'd5; pixel_y = 10'd5;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("t1_originx", 32'(originx), 32);
    check("t1_angle",   32'(angle),   0);
    check("t1_scalex",  32'(scalex),  'h100);
    check("t1_err",     32'(err),     0);
    check("t1_wr_ready", 32'(wr_ready), 1);

    // Angle write lands only at the commit
    idle(2);
    write(2, 90);
    idle(3);
    check("t2_angle_hold", 32'(angle), 0);
    frame();
    check("t2_angle_live", 32'(angle), 90);
    check("t2_commit_hi", 32'(commit), 1);
    tick();
    check("t2_commit_lo", 32'(commit), 0);
    tick();

    // Illegal angle
    write(2, 400);
    check("t3_err", 32'(err), 1);
    frame_full();
    check("t3_angle", 32'(angle), 90);
    check("t3_err_sticky", 32'(err), 1);

    // Auto-animation with wrap, then frame_div=2
    write(2, 350);
    write(7, 'h3D);
    frame_full();
    check("t4_angle_wrap", 32'(angle), 5);
    check("t4_offsety", 32'(offsety), 1);
    write(7, 'h23D);
    frame_full();
    check("t4_div_f1", 32'(angle), 5);
    frame_full();
    check("t4_div_f2", 32'(angle), 5);
    frame_full();
    check("t4_div_f3", 32'(angle), 20);
    check("t4_offsety2", 32'(offsety), 2);

    // Perspective ramp and saturation at 0
    write(7, 'h2);
    write(5, 'h100);
    write(6, 'h10);
    frame_full();
    check("t5_line0", 32'(scaley), 'h100);
    line(0);
    check("t5_line1", 32'(scaley), 'h110);
    check("t5_scalex", 32'(scalex), 'h110);
    write(6, 'hFF00);
    frame_full();
    check("t5_base", 32'(scaley), 'h100);
    line(0);
    check("t5_sat0", 32'(scaley), 0);
    line(1);
    check("t5_sat_hold", 32'(scaley), 0);

    // Write held through commit/anim lands afterwards and overrides animation
    write(7, 'h3D);
    frame_full();
    frame();
    check("t6_ready_commit", 32'(wr_ready), 0);
    wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 24'd100;
    tick();
    check("t6_ready_anim", 32'(wr_ready), 0);
    tick();
    check("t6_ready_back", 32'(wr_ready), 1);
    check("t6_angle_anim", 32'(angle), 50);
    tick();
    wr_valid = 1'b0;
    check("t6_not_live_yet", 32'(angle), 50);
    frame();
    check("t6_host_wins", 32'(angle), 100);
    tick(); tick();
    check("t6_anim_after", 32'(angle), 115);
    check("t6_offsety", 32'(offsety), 5);

    // Write on the frame_evt cycle is part of that commit
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 24'hABC04D;
    p_tick = 1'b1; pixel_x = 10'd0; pixel_y = 10'd480;
    tick();
    wr_valid = 1'b0; idle_coords();
    check("t7_same_cycle", 32'(originx), 'h04D);
    tick(); tick();

    // Reset inside S_COMMIT
    frame();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t8_originx", 32'(originx), 32);
    check("t8_angle",   32'(angle),   0);
    check("t8_offsety", 32'(offsety), 0);
    check("t8_scalex",  32'(scalex),  'h100);
    check("t8_commit",  32'(commit),  0);
    check("t8_ready",   32'(wr_ready), 1);
    check("t8_err",     32'(err),     0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int ev, a;
      reset = ($urandom_range(0, 199) == 0);
      ev = $urandom_range(0, 99);
      if (ev < 4) begin
        p_tick = 1'b1; pixel_x = 10'd0; pixel_y = 10'd480;
      end else if (ev < 20) begin
        p_tick = 1'b1; pixel_x = 10'd639; pixel_y = 10'($urandom_range(0, 479));
      end else if (ev < 25) begin
        p_tick = 1'b0;
        pixel_x = (ev < 23) ? 10'd0 : 10'd639;
        pixel_y = (ev < 23) ? 10'd480 : 10'd10;
      end else begin
        p_tick = 1'($urandom_range(0, 1));
        pixel_x = 10'($urandom_range(0, 799));
        pixel_y = 10'($urandom_range(0, 524));
      end
      wr_valid = ($urandom_range(0, 99) < 35);
      a = $urandom_range(0, 7);
      wr_addr = 3'(a);
      if (a == 2) wr_data = 24'($urandom_range(0, 399)) | (24'($urandom) & 24'hFFFC00);
      else if (a == 7) wr_data = (24'($urandom) & 24'hFF00FF) | 24'($urandom_range(0, 3) << 8);
      else wr_data = 24'($urandom);
      tick();
    end
    reset = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
